// File: rtl/mme_cfg_apb_slave.sv
// -----------------------------------------------------------------------------
// mme_cfg_apb_slave
//   APB completer holding the MME control/status registers. It decodes host
//   reads and writes with zero wait states and holds the matrix configuration
//   and base addresses. It issues a one-cycle start pulse to the engine and
//   tracks the run state (IDLE -> BUSY -> DONE) until the engine reports done.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   psel_i, penable_i    APB select / access-phase enable
//   paddr_i, pwrite_i    APB byte address, direction (1 = write)
//   pwdata_i             APB write data
//   prdata_o             read data, valid while pready_o = 1
//   pready_o             transfer complete (high in the access cycle)
//   pslverr_o            transfer error, valid while pready_o = 1
//   mat_width_o          MAT_CFG register (matrix inner dimension)
//   mat_a/b/c_addr_o     base addresses of A, B and C
//   start_o              one-cycle engine start pulse
//   done_i               one-cycle completion pulse from the engine
// -----------------------------------------------------------------------------
module mme_cfg_apb_slave #(
  parameter logic [31:0] IP_VERSION = 32'h0001_0000,
  parameter int          ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic              pwrite_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [31:0]       mat_width_o,
  output logic [31:0]       mat_a_addr_o,
  output logic [31:0]       mat_b_addr_o,
  output logic [31:0]       mat_c_addr_o,
  output logic              start_o,
  input  logic              done_i
);

  localparam logic [ADDR_W-1:0] ADDR_VER = ADDR_W'('h000);
  localparam logic [ADDR_W-1:0] ADDR_CFG = ADDR_W'('h100);
  localparam logic [ADDR_W-1:0] ADDR_A   = ADDR_W'('h200);
  localparam logic [ADDR_W-1:0] ADDR_B   = ADDR_W'('h204);
  localparam logic [ADDR_W-1:0] ADDR_C   = ADDR_W'('h208);
  localparam logic [ADDR_W-1:0] ADDR_CMD = ADDR_W'('h20C);
  localparam logic [ADDR_W-1:0] ADDR_STS = ADDR_W'('h210);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t      state, state_nxt;
  logic        busy, done;
  logic        setup, wr_en, cmd_start;
  logic [31:0] rd_data_d;
  logic        err_d;
  logic [31:0] prdata_q;
  logic        pready_q, pslverr_q, start_q;
  logic [31:0] width_q, a_addr_q, b_addr_q, c_addr_q;

  assign setup = psel_i & ~penable_i;
  // A write commits only at the edge ending an access phase whose setup
  // decode raised no error; the error flag therefore doubles as a veto.
  assign wr_en     = psel_i & penable_i & pready_q & pwrite_i & ~pslverr_q;
  assign cmd_start = wr_en & (paddr_i == ADDR_CMD) & pwdata_i[0];

  // Setup-phase decode: read data and error response for the coming access.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement leaves it unassigned (no latch).
    rd_data_d = '0;
    err_d     = 1'b0;
    case (paddr_i)
      ADDR_VER: if (pwrite_i) err_d = 1'b1; else rd_data_d = IP_VERSION;
      ADDR_CFG: if (pwrite_i) err_d = busy; else rd_data_d = width_q;
      ADDR_A:   if (pwrite_i) err_d = busy; else rd_data_d = a_addr_q;
      ADDR_B:   if (pwrite_i) err_d = busy; else rd_data_d = b_addr_q;
      ADDR_C:   if (pwrite_i) err_d = busy; else rd_data_d = c_addr_q;
      ADDR_CMD: err_d = pwrite_i ? busy : 1'b1;  // write-only; reads error as 0
      ADDR_STS: if (pwrite_i) err_d = 1'b1; else rd_data_d = {30'b0, busy, done};
      default:  err_d = 1'b1;
    endcase
  end

  // APB response registers: loaded at the setup edge, cleared afterwards so
  // pready/prdata/pslverr are only non-zero during the access cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= setup;
      prdata_q  <= setup ? rd_data_d : '0;
      pslverr_q <= setup ? err_d : 1'b0;
    end
  end

  // Configuration registers, write-protected while busy by the error veto.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q  <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
    end else if (wr_en) begin
      case (paddr_i)
        ADDR_CFG: width_q  <= pwdata_i;
        ADDR_A:   a_addr_q <= pwdata_i;
        ADDR_B:   b_addr_q <= pwdata_i;
        ADDR_C:   c_addr_q <= pwdata_i;
        default:  ;
      endcase
    end
  end

  // Start pulse: high for the single cycle after the accepted command edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= cmd_start;
  end

  // Run-state FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Run-state FSM: next state. done_i only matters while busy.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (cmd_start) state_nxt = ST_BUSY;
      ST_BUSY:          if (done_i)    state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Run-state FSM: status outputs. Done is sticky until the next start.
  always_comb begin
    busy = (state == ST_BUSY);
    done = (state == ST_DONE);
  end

  assign prdata_o     = prdata_q;
  assign pready_o     = pready_q;
  assign pslverr_o    = pslverr_q;
  assign start_o      = start_q;
  assign mat_width_o  = width_q;
  assign mat_a_addr_o = a_addr_q;
  assign mat_b_addr_o = b_addr_q;
  assign mat_c_addr_o = c_addr_q;

endmodule
